// File: rtl/sirv_gnrl_arb_pkg.sv
// ---------------------------------------------------------------------------
// sirv_gnrl_arb_pkg
// Shared definitions for the general arbiters.
//   arb_state_e : arbiter lock state (ST_IDLE / ST_LOCKED)
//   clog2()     : constant function used to check grant-ID widths
// ---------------------------------------------------------------------------
package sirv_gnrl_arb_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_e;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/sirv_gnrl_rrarb_if.sv
// ---------------------------------------------------------------------------
// sirv_gnrl_rrarb_if
// Bundles the N requester channels and the shared downstream channel.
//   req_valid/req_ready/req_last/req_data : requester side, requester i owns
//                                           bit i and data bits [i*DW +: DW]
//   o_valid/o_ready/o_last/o_data/o_id    : shared downstream channel
// Modports:
//   slave  : the arbiter
//   master : the environment (requesters and downstream sink)
// ---------------------------------------------------------------------------
interface sirv_gnrl_rrarb_if #(
    parameter int N  = 4,
    parameter int DW = 32,
    parameter int IW = 2
);
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    req_last;
    logic [N*DW-1:0] req_data;
    logic            o_valid;
    logic            o_ready;
    logic            o_last;
    logic [DW-1:0]   o_data;
    logic [IW-1:0]   o_id;

    modport slave (
        input  req_valid, req_last, req_data, o_ready,
        output req_ready, o_valid, o_last, o_data, o_id
    );

    modport master (
        output req_valid, req_last, req_data, o_ready,
        input  req_ready, o_valid, o_last, o_data, o_id
    );
endinterface

// File: rtl/sirv_gnrl_rrarb_pick.sv
// ---------------------------------------------------------------------------
// sirv_gnrl_rrarb_pick
// Combinational rotating-priority picker: returns the first set bit of req
// searching ptr, ptr+1, ... wrapping at N (not at 2^IW).
//   req     : request vector
//   ptr     : priority base, expected in 0..N-1
//   gnt_oh  : one-hot grant (all zero when no request)
//   gnt_idx : index of the granted bit (0 when no request)
// ---------------------------------------------------------------------------
module sirv_gnrl_rrarb_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt_oh,
    output logic [IW-1:0] gnt_idx
);

    logic found;
    int   j;

    always_comb begin
        gnt_oh  = '0;
        gnt_idx = '0;
        found   = 1'b0;
        j       = 0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr) + k;
            if (j >= N) j = j - N;
            if (!found && req[j]) begin
                found      = 1'b1;
                gnt_oh[j]  = 1'b1;
                gnt_idx    = IW'(j);
            end
        end
    end

endmodule

// File: rtl/sirv_gnrl_rrarb.sv
// ---------------------------------------------------------------------------
// sirv_gnrl_rrarb
// Round-robin arbiter sharing one valid/ready channel among N requesters.
// A granted requester holds the channel from its first presented beat until
// its last beat (req_last) handshakes; priority then rotates past it.
//   clk   : clock
//   rst_n : synchronous reset, active HIGH despite the name
//   bus   : sirv_gnrl_rrarb_if.slave (requester and downstream channels)
// Build option:
//   SIRV_RRARB_OUT_REG_EN : adds a one-entry output register (1 cycle of
//                           latency, full throughput); otherwise the path is
//                           purely combinational.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// ST_IDLE   | no transaction open; picker chooses from ptr each cycle
// ST_LOCKED | owner has presented a beat; only owner is forwarded until its
//           | last beat handshakes
// ---------------------------------------------------------------------------
module sirv_gnrl_rrarb
    import sirv_gnrl_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int DW = 32,
    parameter int IW = 2
) (
    input logic                clk,
    input logic                rst_n,
    sirv_gnrl_rrarb_if.slave   bus
);

    if (IW != clog2(N)) begin : g_iw_chk
        $error("sirv_gnrl_rrarb: IW must equal clog2(N)");
    end

    arb_state_e    state_q, state_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] owner_q, owner_d;
    logic [N-1:0]  gnt_oh;
    logic [IW-1:0] gnt_idx;
    logic [IW-1:0] sel;
    logic [N-1:0]  req_ready_c;
    logic          arb_valid;
    logic          arb_ready;
    logic          arb_last;
    logic [DW-1:0] arb_data;

    function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] x);
        return (x == IW'(N - 1)) ? '0 : x + 1'b1;
    endfunction

    sirv_gnrl_rrarb_pick #(.N(N), .IW(IW)) u_pick (
        .req     (bus.req_valid),
        .ptr     (ptr_q),
        .gnt_oh  (gnt_oh),
        .gnt_idx (gnt_idx)
    );

    always_comb begin
        sel         = (state_q == ST_LOCKED) ? owner_q : gnt_idx;
        arb_valid   = (state_q == ST_LOCKED) ? bus.req_valid[owner_q] : |bus.req_valid;
        arb_last    = bus.req_last[sel];
        arb_data    = '0;
        for (int i = 0; i < N; i++) begin
            if (sel == IW'(i)) arb_data = bus.req_data[i*DW +: DW];
        end

        // While locked the owner sees downstream ready even across bubbles.
        req_ready_c = '0;
        if (state_q == ST_LOCKED) req_ready_c[owner_q] = arb_ready;
        else                      req_ready_c = gnt_oh & {N{arb_ready}};

        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        case (state_q)
            ST_IDLE: begin
                if (arb_valid) begin
                    if (arb_ready && arb_last) begin
                        ptr_d = wrap_inc(gnt_idx);
                    end else begin
                        // Stalled beat or accepted non-last beat: lock source.
                        state_d = ST_LOCKED;
                        owner_d = gnt_idx;
                    end
                end
            end
            ST_LOCKED: begin
                if (arb_valid && arb_ready && arb_last) begin
                    state_d = ST_IDLE;
                    ptr_d   = wrap_inc(owner_q);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
        end
    end

    assign bus.req_ready = req_ready_c;

`ifdef SIRV_RRARB_OUT_REG_EN
    logic          out_full;
    logic          out_last;
    logic [DW-1:0] out_data;
    logic [IW-1:0] out_id;

    assign arb_ready = ~out_full | bus.o_ready;

    always_ff @(posedge clk) begin
        if (rst_n)          out_full <= 1'b0;
        else if (arb_ready) out_full <= arb_valid;
    end

    always_ff @(posedge clk) begin
        if (arb_ready && arb_valid) begin
            out_last <= arb_last;
            out_data <= arb_data;
            out_id   <= sel;
        end
    end

    assign bus.o_valid = out_full;
    assign bus.o_last  = out_last;
    assign bus.o_data  = out_data;
    assign bus.o_id    = out_id;
`else
    assign arb_ready   = bus.o_ready;
    assign bus.o_valid = arb_valid;
    assign bus.o_last  = arb_last;
    assign bus.o_data  = arb_data;
    assign bus.o_id    = sel;
`endif

endmodule

// File: tb/tb_sirv_gnrl_rrarb.sv
// ---------------------------------------------------------------------------
// tb_sirv_gnrl_rrarb
// Directed scenarios followed by randomized traffic, all checked every cycle
// against a transaction-level round-robin model and a beat scoreboard.
// ---------------------------------------------------------------------------
module tb_sirv_gnrl_rrarb;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int IW = 2;

    logic clk;
    logic rst_n;

    sirv_gnrl_rrarb_if #(.N(N), .DW(DW), .IW(IW)) bus ();

    sirv_gnrl_rrarb #(.N(N), .DW(DW), .IW(IW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int            id;
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    int    total;
    int    bad;
    int    log_q[$];
    beat_t sb[$];
    int    tag;

    // reference model: rotating priority base, open transaction and owner
    int    m_ptr;
    bit    m_locked;
    int    m_owner;
`ifdef SIRV_RRARB_OUT_REG_EN
    bit            m_full;
    int            m_qid;
    logic [DW-1:0] m_qdata;
    logic          m_qlast;
`endif

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ptr    = 0;
        m_locked = 0;
        m_owner  = 0;
`ifdef SIRV_RRARB_OUT_REG_EN
        m_full   = 0;
`endif
        sb.delete();
    endtask

    // Called at posedge+1 with inputs applied; checks near the next edge,
    // then advances DUT and model by one clock.
    task automatic step();
        int            g;
        int            src;
        bit            iv;
        bit            ird;
        bit            ev;
        int            eid;
        logic [DW-1:0] ed;
        logic          el;
        logic [N-1:0]  exp_rdy;
        beat_t         b;
        #3;
        g = -1;
        if (!m_locked) begin
            for (int k = 0; k < N; k++) begin
                int i;
                i = (m_ptr + k) % N;
                if (g < 0 && bus.req_valid[i]) g = i;
            end
            src = (g < 0) ? 0 : g;
            iv  = (g >= 0);
        end else begin
            src = m_owner;
            iv  = bus.req_valid[m_owner];
        end
`ifdef SIRV_RRARB_OUT_REG_EN
        ird = !m_full || bus.o_ready;
        ev  = m_full;
        eid = m_qid;
        ed  = m_qdata;
        el  = m_qlast;
`else
        ird = bus.o_ready;
        ev  = iv;
        eid = src;
        ed  = bus.req_data[src*DW +: DW];
        el  = bus.req_last[src];
`endif
        exp_rdy = '0;
        if (m_locked || iv) exp_rdy[src] = ird;

        chk("o_valid", 64'(bus.o_valid), 64'(ev));
        chk("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
        if (ev) begin
            chk("o_id", 64'(bus.o_id), 64'(eid));
            chk("o_data", 64'(bus.o_data), 64'(ed));
            chk("o_last", 64'(bus.o_last), 64'(el));
        end

        if (iv && ird) begin
            b.id   = src;
            b.data = bus.req_data[src*DW +: DW];
            b.last = bus.req_last[src];
            sb.push_back(b);
        end
        if (bus.o_valid && bus.o_ready) begin
            log_q.push_back(int'(bus.o_id));
            if (sb.size() == 0) begin
                chk("sb_depth", 64'(sb.size()), 64'(1));
            end else begin
                b = sb.pop_front();
                chk("sb_id", 64'(bus.o_id), 64'(b.id));
                chk("sb_data", 64'(bus.o_data), 64'(b.data));
            end
        end

        @(posedge clk);
        if (rst_n) begin
            model_reset();
        end else begin
            if (iv && ird && bus.req_last[src]) begin
                m_locked = 0;
                m_ptr    = (src + 1) % N;
            end else if (iv && !m_locked) begin
                m_locked = 1;
                m_owner  = src;
            end
`ifdef SIRV_RRARB_OUT_REG_EN
            if (ird) begin
                m_full = iv;
                if (iv) begin
                    m_qid   = src;
                    m_qdata = bus.req_data[src*DW +: DW];
                    m_qlast = bus.req_last[src];
                end
            end
`endif
        end
        #1;
    endtask

    task automatic drive(input logic [N-1:0] v, input logic [N-1:0] l, input logic rdy);
        bus.req_valid = v;
        bus.req_last  = l;
        bus.o_ready   = rdy;
        for (int i = 0; i < N; i++) bus.req_data[i*DW +: DW] = {8'(i + 1), 24'(tag)};
        step();
    endtask

    task automatic drain();
        for (int c = 0; c < 3; c++) drive('0, '0, 1'b1);
    endtask

    task automatic reset_dut();
        rst_n         = 1'b1;
        bus.req_valid = '0;
        bus.req_last  = '0;
        bus.req_data  = '0;
        bus.o_ready   = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        model_reset();
        log_q.delete();
    endtask

    initial begin
        int e1[5];
        int e2[4];
        int e4[3];
        total = 0;
        bad   = 0;
        tag   = 0;
        e1 = '{0, 1, 2, 3, 0};
        e2 = '{2, 2, 2, 0};
        e4 = '{1, 1, 3};

        // 1: all single-beat requesters, sink always ready
        reset_dut();
        drive('0, '0, 1'b1);
        for (int c = 0; c < 5; c++) drive(4'b1111, 4'b1111, 1'b1);
        drain();
        chk("t1_count", 64'(log_q.size()), 64'(5));
        for (int i = 0; i < 5; i++) chk("t1_order", 64'(log_q[i]), 64'(e1[i]));

        // 2: 3-beat burst from 2, req 0 arrives mid-burst
        reset_dut();
        tag = 2;
        drive(4'b0100, 4'b0000, 1'b1);
        drive(4'b0101, 4'b0000, 1'b1);
        drive(4'b0101, 4'b0100, 1'b1);
        drive(4'b0001, 4'b0001, 1'b1);
        drain();
        chk("t2_count", 64'(log_q.size()), 64'(4));
        for (int i = 0; i < 4; i++) chk("t2_order", 64'(log_q[i]), 64'(e2[i]));

        // 3: stalled sink with a competing request
        reset_dut();
        tag = 3;
        drive(4'b0001, 4'b0001, 1'b0);
        for (int c = 0; c < 4; c++) drive(4'b0011, 4'b0001, 1'b0);
        drive(4'b0011, 4'b0011, 1'b1);
        drive(4'b0010, 4'b0010, 1'b1);
        drain();
`ifndef SIRV_RRARB_OUT_REG_EN
        chk("t3_count", 64'(log_q.size()), 64'(2));
        chk("t3_first", 64'(log_q[0]), 64'(0));
        chk("t3_next", 64'(log_q[1]), 64'(1));
`endif

        // 4: owner bubbles while another requester waits
        reset_dut();
        tag = 4;
        drive(4'b0010, 4'b0000, 1'b1);
        drive(4'b1000, 4'b1000, 1'b1);
        drive(4'b1000, 4'b1000, 1'b1);
        drive(4'b1010, 4'b1010, 1'b1);
        drive(4'b1000, 4'b1000, 1'b1);
        drain();
        chk("t4_count", 64'(log_q.size()), 64'(3));
        for (int i = 0; i < 3; i++) chk("t4_order", 64'(log_q[i]), 64'(e4[i]));

        // 5: reset in the middle of a locked burst from 3
        reset_dut();
        tag = 5;
        drive(4'b1000, 4'b0000, 1'b1);
        rst_n = 1'b1;
        drive(4'b0000, 4'b0000, 1'b0);
        rst_n = 1'b0;
        log_q.delete();
        drive(4'b1111, 4'b1111, 1'b1);
        bus.req_valid = '0;
        drain();
        chk("t5_count", 64'(log_q.size()), 64'(1));
        chk("t5_first", 64'(log_q[0]), 64'(0));

        // 6: sink ready toggling, scoreboard guards drop/duplicate
        reset_dut();
        for (int c = 0; c < 8; c++) begin
            tag = 100 + c;
            drive(4'b1111, 4'b1111, (c % 2) == 0);
        end
        drain();
        chk("t6_left", 64'(sb.size()), 64'(0));

        // randomized traffic
        reset_dut();
        for (int c = 0; c < 3000; c++) begin
            rst_n         = ($urandom_range(0, 99) == 0);
            bus.req_valid = N'($urandom);
            bus.req_last  = N'($urandom) | N'($urandom);
            bus.o_ready   = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) bus.req_data[i*DW +: DW] = $urandom;
            step();
        end
        rst_n = 1'b0;
        drain();
        chk("rand_left", 64'(sb.size()), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sirv_gnrl_rrarb.md
Name: sirv_gnrl_rrarb

Overview:
Round-robin arbiter that shares one downstream valid/ready channel among N requesters, with multi-beat lock.
- Each requester presents beats; the last beat of a transaction is flagged by req_last.
- A granted requester keeps the channel from its first presented beat until its last beat handshakes.
- Sits in front of shared pipeline resources (e.g. a single bus port or register-file write port) built from the general DFF library.

Parameters:
N, 4, number of requesters (2..16)
DW, 32, data width per requester
IW, 2, grant ID width; must equal clog2(N)

Ports:
clk  input  1  clock
rst_n  input  1  synchronous reset, active-high (reset when rst_n==1 at posedge clk)
req_valid  input  N  per-requester beat valid
req_ready  output  N  per-requester beat accepted
req_last  input  N  per-requester last-beat flag
req_data  input  N*DW  requester i uses bits [i*DW +: DW]
o_valid  output  1  downstream beat valid
o_ready  input  1  downstream ready
o_last  output  1  forwarded last flag
o_data  output  DW  forwarded data
o_id  output  IW  index of the requester driving the current beat

Behaviour:
- Registers: ptr (IW bits, rotating priority base), state (IDLE/LOCKED), owner (IW bits).
- Synchronous reset: ptr=0, state=IDLE, owner=0. Combinationally after reset with no requests: o_valid=0, req_ready=0.
- IDLE:
  - grant = first index i with req_valid[i]=1, searching ptr, ptr+1, ... mod N.
  - o_valid = |req_valid; o_id = grant; o_data/o_last are taken from the grant requester.
  - req_ready[grant] = o_ready; all other req_ready bits are 0.
- Zero-latency pass-through: no cycle is added between a requester and the output.
- Transitions:
  - IDLE, o_valid & o_ready & o_last -> stay IDLE; ptr <= (grant+1) mod N.
  - IDLE, o_valid & ~(o_ready & o_last) -> LOCKED; owner <= grant. This covers both a stalled beat and an accepted non-last beat.
  - LOCKED: only the owner is forwarded. o_valid = req_valid[owner]; req_ready[owner] = o_ready; other req_ready bits are 0. o_id = owner.
  - LOCKED, o_valid & o_ready & o_last -> IDLE; ptr <= (owner+1) mod N.
- Grant stability: once o_valid is asserted, o_id/o_data source must not change until the last beat handshakes. A higher-priority request arriving mid-transaction is ignored.
- Owner drops valid while LOCKED: the lock is held and o_valid=0. Bubbles are allowed and no other requester is served.
- ptr wrap: owner=N-1 completes -> ptr=0.
- N not a power of two: the picker ignores indices >= N, and the ptr increment wraps at N, not 2^IW.
- rst_n asserted mid-transaction: the lock is aborted and state returns to IDLE/ptr=0 next cycle. Requesters are responsible for restarting the transaction.
- Simultaneous events: completion and new requests in the same cycle. The next grant uses the updated ptr on the following cycle.

Optional Feature:
SIRV_RRARB_OUT_REG_EN
- Defined:
  - A one-entry output register (valid, data, last, id) sits between the arbiter and the o_* ports.
  - Internal ready = ~out_full | o_ready, giving full throughput and 1 cycle of latency.
  - Lock and ptr updates occur on the internal handshake.
  - Reset clears out_full.
- Undefined: pure combinational path as described above, 0 cycles of latency.

Decomposition:
- Shared package sirv_gnrl_arb_pkg:
  - state encodings ST_IDLE=1'b0, ST_LOCKED=1'b1;
  - a clog2 helper constant function for IW checks.
- One sub-module, sirv_gnrl_rrarb_pick: combinational rotating-priority picker.
  - Inputs: req vector and ptr.
  - Outputs: one-hot grant and grant index.
  - Reusable by other arbiters.

Test Plan:
1. Reset then all req_valid=4'b1111, single-beat (req_last=1), o_ready=1 constantly -> o_id sequence 0,1,2,3,0, one beat per cycle.
2. Req 2 sends a 3-beat burst while req 0 asserts valid at beat 2 -> o_id=2 for all 3 beats, req_ready[0]=0 throughout; req 0 is granted on the cycle after 2's last beat; ptr=3.
3. req_valid=4'b0001, o_ready=0 for 5 cycles, req 1 raises valid in cycle 2 -> o_id stays 0 and o_data stays stable for all 5 cycles; after o_ready=1 and last, ptr=1, and req 1 is granted next.
4. Owner 1 deasserts valid mid-burst for 2 cycles while req 3 is valid -> o_valid=0 for those 2 cycles, req_ready[3]=0; the burst resumes from owner 1.
5. rst_n=1 for one cycle during a LOCKED burst from requester 3 -> next cycle state=IDLE, ptr=0; with all valid, o_id=0.
6. With SIRV_RRARB_OUT_REG_EN, repeat scenario 1 -> same ID order with one extra cycle of latency. With o_ready toggling 1,0,1,0, no beat is dropped or duplicated, checked against a scoreboard.
